// File: rtl/eon_uart_fifo.sv
// eon_uart_fifo: full-duplex UART, runtime baud divisor, TX/RX FIFOs.
// Ports: clk/rst (sync, active-high); div_wr/div_in set cycles per bit;
//   tx_data/tx_valid/tx_ready push TX FIFO; rx_data/rx_valid/rx_ready
//   pop RX FIFO (show-ahead); tx_level/rx_level occupancy; tx_busy;
//   sticky overrun/frame_err cleared by clr_err; rx/tx serial pins.
module eon_uart_fifo #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 139,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [LVL_W-1:0]     tx_level,
  output logic [LVL_W-1:0]     rx_level,
  output logic                 tx_busy,
  output logic                 overrun,
  output logic                 frame_err,
  input  logic                 clr_err,
  input  logic                 rx,
  output logic                 tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [LVL_W-1:0]     FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [BW-1:0]        LASTB   = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
  } rx_st_t;

  logic [DIV_WIDTH-1:0] r_div;

  always_ff @(posedge clk) begin
    if (rst)
      r_div <= DEF_DIV;
    else if (div_wr)
      r_div <= (div_in < MIN_DIV) ? MIN_DIV : div_in;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] r_txm [FIFO_DEPTH];
  logic [LVL_W-1:0]     r_txw, r_txr;
  logic [LVL_W-1:0]     w_tx_lvl;
  logic                 w_tx_ne, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_lvl  = r_txw - r_txr;
  assign w_tx_ne   = w_tx_lvl != '0;
  assign tx_ready  = w_tx_lvl != FULL;
  assign tx_level  = w_tx_lvl;
  assign w_tx_push = tx_valid & tx_ready;
  assign w_tx_head = r_txm[r_txr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_txm[r_txw[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txw <= '0;
      r_txr <= '0;
    end else begin
      if (w_tx_push) r_txw <= r_txw + 1'b1;
      if (w_tx_pop)  r_txr <= r_txr + 1'b1;
    end
  end

  // TX FSM
  tx_st_t               r_tst;
  logic [DIV_WIDTH-1:0] r_tcnt, r_tdiv;
  logic [BW-1:0]        r_tbit;
  logic [DATA_BITS-1:0] r_tsh;
  logic                 r_tx;
  logic                 w_tlast;

  assign w_tlast  = r_tcnt == r_tdiv - 1'b1;
  // Head is taken from IDLE or straight out of the last STOP cycle,
  // so queued bytes go out with no idle gap.
  assign w_tx_pop = w_tx_ne &&
                    (r_tst == T_IDLE ||
                     (r_tst == T_STOP && w_tlast));
  assign tx       = r_tx;
  assign tx_busy  = (r_tst != T_IDLE) || w_tx_ne;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tst  <= T_IDLE;
      r_tx   <= 1'b1;
      r_tcnt <= '0;
      r_tdiv <= DEF_DIV;
      r_tbit <= '0;
      r_tsh  <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
      unique case (r_tst)
        T_IDLE: begin
          r_tcnt <= '0;
          if (w_tx_ne) begin
            r_tst  <= T_START;
            r_tx   <= 1'b0;
            r_tdiv <= r_div;
            r_tsh  <= w_tx_head;
          end
        end
        T_START: if (w_tlast) begin
          r_tst  <= T_DATA;
          r_tx   <= r_tsh[0];
          r_tcnt <= '0;
          r_tbit <= '0;
        end
        T_DATA: if (w_tlast) begin
          r_tcnt <= '0;
          if (r_tbit == LASTB) begin
            r_tst <= T_STOP;
            r_tx  <= 1'b1;
          end else begin
            r_tbit <= r_tbit + 1'b1;
            r_tx   <= r_tsh[1];
            r_tsh  <= r_tsh >> 1;
          end
        end
        T_STOP: if (w_tlast) begin
          r_tcnt <= '0;
          if (w_tx_ne) begin
            r_tst  <= T_START;
            r_tx   <= 1'b0;
            r_tdiv <= r_div;
            r_tsh  <= w_tx_head;
          end else begin
            r_tst <= T_IDLE;
          end
        end
      endcase
    end
  end

  // RX synchroniser; r_s3 is the previous synchronised value
  logic r_s1, r_s2, r_s3;
  logic w_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_fall = r_s3 & ~r_s2;

  // RX FIFO
  logic [DATA_BITS-1:0] r_rxm [FIFO_DEPTH];
  logic [LVL_W-1:0]     r_rxw, r_rxr;
  logic [LVL_W-1:0]     w_rx_lvl;
  logic                 w_rx_push, w_rx_pop, w_rx_full;

  // RX FSM state
  rx_st_t               r_rst;
  logic [DIV_WIDTH-1:0] r_rcnt, r_rdiv;
  logic [BW-1:0]        r_rbit;
  logic [DATA_BITS-1:0] r_rsh;
  logic                 r_ovr, r_fe;
  logic                 w_rlast, w_rhalf, w_stop;
  logic                 w_ovr_set, w_fe_set;

  assign w_rx_lvl  = r_rxw - r_rxr;
  assign w_rx_full = w_rx_lvl == FULL;
  assign rx_valid  = w_rx_lvl != '0;
  assign rx_level  = w_rx_lvl;
  assign rx_data   = r_rxm[r_rxr[AW-1:0]];
  assign w_rx_pop  = rx_valid & rx_ready;

  assign w_rlast   = r_rcnt == r_rdiv - 1'b1;
  assign w_rhalf   = r_rcnt == (r_rdiv >> 1) - 1'b1;
  assign w_stop    = (r_rst == R_STOP) && w_rlast;
  // A pop in the same cycle frees the slot being written.
  assign w_rx_push = w_stop && r_s2 && (!w_rx_full || w_rx_pop);
  assign w_ovr_set = w_stop && r_s2 && w_rx_full && !w_rx_pop;
  assign w_fe_set  = w_stop && !r_s2;
  assign overrun   = r_ovr;
  assign frame_err = r_fe;

  always_ff @(posedge clk) begin
    if (w_rx_push)
      r_rxm[r_rxw[AW-1:0]] <= r_rsh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxw <= '0;
      r_rxr <= '0;
    end else begin
      if (w_rx_push) r_rxw <= r_rxw + 1'b1;
      if (w_rx_pop)  r_rxr <= r_rxr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (clr_err) r_ovr <= 1'b0;
      if (w_fe_set)     r_fe  <= 1'b1;
      else if (clr_err) r_fe  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst  <= R_IDLE;
      r_rcnt <= '0;
      r_rdiv <= DEF_DIV;
      r_rbit <= '0;
      r_rsh  <= '0;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
      unique case (r_rst)
        R_IDLE: begin
          r_rcnt <= '0;
          if (w_fall) begin
            r_rst  <= R_START;
            r_rdiv <= r_div;
          end
        end
        // Mid-start check rejects glitches shorter than half a bit.
        R_START: if (w_rhalf) begin
          r_rcnt <= '0;
          r_rbit <= '0;
          r_rst  <= r_s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (w_rlast) begin
          r_rcnt <= '0;
          r_rsh  <= {r_s2, r_rsh[DATA_BITS-1:1]};
          if (r_rbit == LASTB) r_rst <= R_STOP;
          else r_rbit <= r_rbit + 1'b1;
        end
        R_STOP: if (w_rlast) begin
          r_rcnt <= '0;
          r_rst  <= r_s2 ? R_IDLE : R_BREAK;
        end
        R_BREAK: begin
          r_rcnt <= '0;
          if (r_s2) r_rst <= R_IDLE;
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eon_uart_fifo.sv
// tb_eon_uart_fifo: scoreboard bench for eon_uart_fifo.
// Line-level TX frame model and RX byte scoreboard, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_eon_uart_fifo;

  logic       clk, rst, div_wr, clr_err;
  logic [15:0] div_in;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [2:0] tx_level, rx_level;
  logic       tx_busy, overrun, frame_err, rx, tx;
  logic       loop, rx_drv;

  assign rx = loop ? tx : rx_drv;

  eon_uart_fifo #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .div_wr(div_wr), .div_in(div_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
    .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err),
    .rx(rx), .tx(tx)
  );

  typedef struct {
    logic [7:0] d;
    int         div;
  } txexp_t;

  txexp_t     txq[$];
  logic [7:0] rxq[$];
  int         tx_starts[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected line level k cycles into a frame: start, LSB-first, stop.
  function automatic logic exp_bit(logic [7:0] d, int div, int k);
    int idx;
    idx = k / div;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  // TX monitor: every falling edge of tx starts a frame to check.
  initial begin
    logic   prev, ab;
    int     bad;
    txexp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx) begin
        tx_starts.push_back(cyc);
        if (txq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_frame @%0d: got a frame, want none", cyc);
        end else begin
          e = txq.pop_front();
          bad = 0;
          ab = 1'b0;
          for (int k = 0; k < 10 * e.div; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
              break;
            end
            if (tx !== exp_bit(e.d, e.div, k)) bad++;
          end
          if (!ab) chk($sformatf("tx_frame_%02h", e.d), bad, 0);
        end
      end
      prev = tx;
    end
  end

  // RX monitor: compare every popped byte with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rx_valid && rx_ready) begin
        if (rxq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_data @%0d: got %0h, want none",
                   cyc, rx_data);
        end else begin
          chk("rx_data", rx_data, rxq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_div(int d);
    div_wr = 1;
    div_in = 16'(d);
    tick(1);
    div_wr = 0;
  endtask

  task automatic push_tx(logic [7:0] b, int div, bit lb);
    for (int i = 0; i < 5000 && !tx_ready; i++) tick(1);
    chk("tx_ready_wait", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1;
    txq.push_back('{b, div});
    if (lb) rxq.push_back(b);
    tick(1);
    tx_valid = 0;
  endtask

  task automatic send_rx(logic [7:0] b, bit stop, int d);
    rx_drv = 0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(d);
    end
    rx_drv = stop;
    tick(d);
  endtask

  task automatic wait_idle(int lim, output int when);
    for (int i = 0; i < lim && tx_busy; i++) @(negedge clk);
    when = cyc;
    chk("tx_idle_wait", tx_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rx_ready = 1;
    for (int i = 0; i < 400 && rx_valid; i++) tick(1);
    rx_ready = 0;
    chk("rx_drain", rx_valid, 0);
    chk("rxq_empty", rxq.size(), 0);
  endtask

  initial begin
    int pc, bc, d;
    logic [7:0] b;
    rst = 1; div_wr = 0; div_in = 0; clr_err = 0;
    tx_data = 0; tx_valid = 0; rx_ready = 0;
    loop = 0; rx_drv = 1;
    tick(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 0;
    tick(1);

    // Default rate, single 0x55 frame
    tx_starts.delete();
    pc = cyc;
    push_tx(8'h55, 139, 0);
    wait_idle(3000, bc);
    chk("frames_55", tx_starts.size(), 1);
    if (tx_starts.size() >= 1) begin
      chk("tx_latency", tx_starts[0] - pc, 2);
      chk("busy_drop", bc - tx_starts[0], 1390);
    end

    // Loopback at D=16, four back-to-back bytes
    set_div(16);
    loop = 1;
    tx_starts.delete();
    push_tx(8'h00, 16, 1);
    push_tx(8'hFF, 16, 1);
    push_tx(8'hA5, 16, 1);
    push_tx(8'h3C, 16, 1);
    for (int i = 0; i < 1500 && rx_level != 4; i++) tick(1);
    chk("lb_rx_level", rx_level, 4);
    chk("lb_overrun", overrun, 0);
    chk("lb_frame_err", frame_err, 0);
    chk("lb_frames", tx_starts.size(), 4);
    if (tx_starts.size() >= 4)
      for (int i = 1; i < 4; i++)
        chk("lb_gap", tx_starts[i] - tx_starts[i-1], 160);
    drain();
    loop = 0;

    // Overrun: five frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      send_rx(8'(8'h11 + i), 1, 16);
      rx_drv = 1;
      tick(4);
    end
    chk("ovr_rx_level", rx_level, 4);
    chk("ovr_flag", overrun, 1);
    for (int i = 0; i < 4; i++) rxq.push_back(8'(8'h11 + i));
    drain();
    clr_err = 1;
    tick(1);
    clr_err = 0;
    chk("ovr_clear", overrun, 0);

    // Framing error then a clean frame
    send_rx(8'h81, 0, 16);
    tick(500 - 16);
    rx_drv = 1;
    tick(40);
    chk("fe_flag", frame_err, 1);
    chk("fe_rx_level", rx_level, 0);
    rxq.push_back(8'h42);
    send_rx(8'h42, 1, 16);
    rx_drv = 1;
    tick(8);
    chk("fe_next_level", rx_level, 1);
    chk("fe_sticky", frame_err, 1);
    drain();
    clr_err = 1;
    tick(1);
    clr_err = 0;
    chk("fe_clear", frame_err, 0);

    // Short glitch at D=139 is rejected
    set_div(139);
    rx_drv = 0;
    tick(30);
    rx_drv = 1;
    tick(300);
    chk("gl_rx_level", rx_level, 0);
    chk("gl_frame_err", frame_err, 0);
    chk("gl_overrun", overrun, 0);

    // Divisor change in flight: old rate kept until frame end
    tx_starts.delete();
    push_tx(8'($urandom), 139, 0);
    push_tx(8'($urandom), 16, 0);
    for (int i = 0; i < 100 && tx_starts.size() == 0; i++) tick(1);
    tick(200);
    set_div(16);
    wait_idle(4000, bc);
    chk("dv_frames", tx_starts.size(), 2);
    if (tx_starts.size() >= 2) begin
      chk("dv_first", tx_starts[1] - tx_starts[0], 1390);
      chk("dv_second", bc - tx_starts[1], 160);
    end

    // Random loopback bursts at random divisors
    loop = 1;
    rx_ready = 1;
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(8, 24);
      set_div(d);
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom);
        push_tx(b, d, 1);
        tick($urandom_range(0, 150));
      end
      wait_idle(3000, bc);
      tick(3 * d);
      chk("rnd_rxq", rxq.size(), 0);
      chk("rnd_flags", {overrun, frame_err}, 0);
    end
    rx_ready = 0;
    loop = 0;

    // Reset mid-frame with bytes queued
    set_div(16);
    send_rx(8'h00, 0, 16);
    rx_drv = 1;
    tick(40);
    chk("rm_fe_set", frame_err, 1);
    tx_starts.delete();
    for (int i = 0; i < 4; i++) push_tx(8'($urandom), 16, 0);
    for (int i = 0; i < 100 && tx_starts.size() == 0; i++) tick(1);
    tick(48);
    chk("rm_pre_level", tx_level, 3);
    rst = 1;
    tick(1);
    chk("rm_tx", tx, 1);
    chk("rm_tx_level", tx_level, 0);
    chk("rm_tx_busy", tx_busy, 0);
    chk("rm_frame_err", frame_err, 0);
    chk("rm_overrun", overrun, 0);
    rst = 0;
    txq.delete();
    rxq.delete();
    tx_starts.delete();
    push_tx(8'h5A, 139, 0);
    wait_idle(3000, bc);
    chk("rm_frames", tx_starts.size(), 1);
    if (tx_starts.size() >= 1)
      chk("rm_div_reset", bc - tx_starts[0], 1390);

    chk("txq_empty", txq.size(), 0);
    chk("rxq_final", rxq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
